// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin two-port arbiter and byte/half/word sequencer for a word-wide data memory
module dmem_ctrl #(
    parameter int MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic        a_req_we,
    input  logic [1:0]  a_req_size,
    input  logic [31:0] a_req_addr,
    input  logic [31:0] a_req_wdata,
    output logic        a_rsp_valid,
    output logic [31:0] a_rsp_rdata,
    output logic        a_rsp_err,
    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic        b_req_we,
    input  logic [1:0]  b_req_size,
    input  logic [31:0] b_req_addr,
    input  logic [31:0] b_req_wdata,
    output logic        b_rsp_valid,
    output logic [31:0] b_rsp_rdata,
    output logic        b_rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ERR  = 3'd1;
    localparam logic [2:0] RD   = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] WR   = 3'd4;
    localparam logic [2:0] RSP  = 3'd5;

    logic [2:0]  state, state_nxt;
    logic        port, we, last_a;
    logic [1:0]  size, lane;
    logic [15:0] wdata_lo;
    logic        grant_b, accept, bad, sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata;
    logic [4:0]  shift;
    logic [31:0] lane_mask, loaded, merged;
    logic        rsp_a, rsp_b;

    // Grant, request selection, error decode and lane extract/merge
    always_comb begin
        grant_b   = b_req_valid && (!a_req_valid || last_a);
        a_req_ready = state == IDLE && !grant_b;
        b_req_ready = state == IDLE && grant_b;
        accept    = (a_req_valid && a_req_ready) || (b_req_valid && b_req_ready);
        sel_we    = grant_b ? b_req_we : a_req_we;
        sel_size  = grant_b ? b_req_size : a_req_size;
        sel_addr  = grant_b ? b_req_addr : a_req_addr;
        sel_wdata = grant_b ? b_req_wdata : a_req_wdata;
        bad       = sel_size == 2'b11 || (sel_size == 2'b01 && sel_addr[0]) ||
                    (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) ||
                    ((sel_addr & ~32'd3) > 32'(MEM_BYTES - 4));
        shift     = {lane, 3'b000};
        lane_mask = size == 2'b00 ? 32'h0000_00FF << shift : 32'h0000_FFFF << shift;
        loaded    = size == 2'b10 ? mem_rdata :
                    (mem_rdata >> shift) & (size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF);
        merged    = (mem_rdata & ~lane_mask) | (({16'b0, wdata_lo} << shift) & lane_mask);
        rsp_a     = state_nxt == RSP && !port;
        rsp_b     = state_nxt == RSP && port;
    end

    // Transaction sequencing: errors skip memory, word stores skip the read
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = !accept ? IDLE : bad ? ERR :
                                 (sel_we && sel_size == 2'b10) ? WR : RD;
            ERR:     state_nxt = RSP;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = we ? WR : RSP;
            WR:      state_nxt = RSP;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered state, memory strobes, held address/data and response pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            port        <= 1'b0;
            we          <= 1'b0;
            size        <= 2'b00;
            lane        <= 2'b00;
            wdata_lo    <= '0;
            last_a      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rsp_err   <= 1'b0;
            b_rsp_err   <= 1'b0;
            a_rsp_rdata <= '0;
            b_rsp_rdata <= '0;
        end else begin
            state       <= state_nxt;
            mem_rd      <= state_nxt == RD;
            mem_wr      <= state_nxt == WR;
            a_rsp_valid <= rsp_a;
            b_rsp_valid <= rsp_b;
            a_rsp_err   <= rsp_a && state == ERR;
            b_rsp_err   <= rsp_b && state == ERR;
            a_rsp_rdata <= (rsp_a && state == CAP) ? loaded : '0;
            b_rsp_rdata <= (rsp_b && state == CAP) ? loaded : '0;
            if (accept) begin
                port      <= grant_b;
                we        <= sel_we;
                size      <= sel_size;
                lane      <= sel_addr[1:0];
                wdata_lo  <= sel_wdata[15:0];
                last_a    <= !grant_b;
                mem_addr  <= sel_addr & ~32'd3;
                mem_wdata <= sel_wdata;
            end
            if (state == CAP && we)
                mem_wdata <= merged;
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and random requests on both ports checked against a byte-array reference model
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0;
    logic [1:0]  a_req_size = 2'b00;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic        a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
    logic [1:0]  b_req_size = 2'b00;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic [7:0]  mem [32];
    logic [7:0]  ref_mem [32];
    req_t        rq [2];
    int          checks = 0;
    int          errors = 0;
    int          last_served = 1;
    logic [31:0] got_rdata;

    dmem_ctrl #(.MEM_BYTES(32)) dut (
        .clk(clk), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_size(a_req_size), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata), .a_rsp_err(a_rsp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_size(b_req_size), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata), .b_rsp_err(b_rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous little-endian memory: read data appears the cycle after mem_rd
    always @(posedge clk) begin
        if (mem_rd && mem_addr < 32)
            mem_rdata <= {mem[mem_addr[4:0] + 5'd3], mem[mem_addr[4:0] + 5'd2],
                          mem[mem_addr[4:0] + 5'd1], mem[mem_addr[4:0]]};
        if (mem_wr && mem_addr < 32)
            for (int i = 0; i < 4; i++) mem[mem_addr[4:0] + 5'(i)] <= mem_wdata[8*i +: 8];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input req_t r);
        return r.size == 3 || (r.size == 1 && r.addr % 2 != 0) ||
               (r.size == 2 && r.addr % 4 != 0) || ((r.addr & ~32'd3) > 32'd28);
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    function automatic logic [31:0] ref_load(input req_t r);
        int a = int'(r.addr);
        if (r.size == 0) return {24'b0, ref_mem[a]};
        if (r.size == 1) return {16'b0, ref_mem[a+1], ref_mem[a]};
        return ref_word(a);
    endfunction

    task automatic ref_store(input req_t r);
        int a = int'(r.addr);
        int n = r.size == 0 ? 1 : r.size == 1 ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[a+i] = r.wdata[8*i +: 8];
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.we    = 1'($urandom_range(0, 1));
        r.size  = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
        r.addr  = $urandom_range(0, 7) == 0 ? 32'($urandom_range(29, 40)) : 32'($urandom_range(0, 31));
        if ($urandom_range(0, 2) != 0)
            r.addr = r.addr & ~(r.size == 2 ? 32'd3 : r.size == 1 ? 32'd1 : 32'd0);
        if ($urandom_range(0, 30) == 0) r.addr = 32'hFFFF_FFF0;
        r.wdata = $urandom;
        return r;
    endfunction

    // Present rq[0] on A (if va) and rq[1] on B (if vb), serve both, check every cycle
    task automatic run(input bit va, input bit vb);
        bit pend0 = va, pend1 = vb, busy = 0, e_err = 0, e_rd = 0;
        int k = 0, g = 0, e_wr = 0, e_rsp = 0;
        logic [31:0] e_rdata = '0, e_wdata = '0, e_addr = '0;
        req_t r;
        a_req_valid = va; a_req_we = rq[0].we; a_req_size = rq[0].size;
        a_req_addr = rq[0].addr; a_req_wdata = rq[0].wdata;
        b_req_valid = vb; b_req_we = rq[1].we; b_req_size = rq[1].size;
        b_req_addr = rq[1].addr; b_req_wdata = rq[1].wdata;
        for (int budget = 0; budget < 60 && (pend0 || pend1 || busy); budget++) begin
            #1;
            if (busy) begin
                k++;
                chk("mem_rd", mem_rd, k == 1 && e_rd);
                chk("mem_wr", mem_wr, k == e_wr);
                if (k == 1 && e_rd) chk("rd_addr", mem_addr, e_addr);
                if (k == e_wr) begin
                    chk("wr_addr", mem_addr, e_addr);
                    chk("wr_data", mem_wdata, e_wdata);
                end
                chk("rsp_valid", g ? b_rsp_valid : a_rsp_valid, k == e_rsp);
                chk("other_rsp", g ? a_rsp_valid : b_rsp_valid, 0);
                if (k == e_rsp) begin
                    got_rdata = g ? b_rsp_rdata : a_rsp_rdata;
                    chk("rsp_err", g ? b_rsp_err : a_rsp_err, e_err);
                    chk("rsp_rdata", got_rdata, e_rdata);
                    busy = 0;
                end
            end else begin
                chk("idle_quiet", {28'b0, a_rsp_valid, b_rsp_valid, mem_rd, mem_wr}, 0);
                if (pend0 || pend1) begin
                    g = (pend0 && pend1) ? (last_served == 0 ? 1 : 0) : (pend0 ? 0 : 1);
                    if (pend0) chk("a_ready", a_req_ready, g == 0);
                    if (pend1) chk("b_ready", b_req_ready, g == 1);
                    r = rq[g];
                    e_err   = is_bad(r);
                    e_rd    = !e_err && (!r.we || r.size != 2);
                    e_wr    = (e_err || !r.we) ? 0 : r.size == 2 ? 1 : 3;
                    e_rsp   = e_err ? 2 : !r.we ? 3 : r.size == 2 ? 2 : 4;
                    e_rdata = (e_err || r.we) ? 32'd0 : ref_load(r);
                    e_addr  = r.addr & ~32'd3;
                    if (!e_err && r.we) begin
                        ref_store(r);
                        e_wdata = ref_word(int'(e_addr));
                    end
                    last_served = g;
                    @(posedge clk);
                    #1;
                    if (g == 0) begin a_req_valid = 0; pend0 = 0; end
                    else begin b_req_valid = 0; pend1 = 0; end
                    busy = 1;
                    k = 0;
                end
            end
            @(negedge clk);
        end
        chk("budget", {29'b0, pend0, pend1, busy}, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin mem[i] = 8'(i); ref_mem[i] = 8'(i); end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_strobes", {28'b0, mem_rd, mem_wr, a_rsp_valid, b_rsp_valid}, 0);
        chk("rst_err", {30'b0, a_rsp_err, b_rsp_err}, 0);
        chk("rst_a_rdata", a_rsp_rdata, 0);
        chk("rst_b_rdata", b_rsp_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        reset = 1;

        rq[0] = '{0, 2'd2, 32'h00, 32'h0};
        rq[1] = '{0, 2'd2, 32'h10, 32'h0};
        run(1, 1);
        rq[0] = '{0, 2'd2, 32'h04, 32'h0};
        run(1, 0);
        chk("plan_word4", got_rdata, 32'h0706_0504);
        rq[0] = '{0, 2'd2, 32'h08, 32'h0};
        rq[1] = '{0, 2'd2, 32'h14, 32'h0};
        run(1, 1);
        chk("plan_pair2_a_last", got_rdata, 32'h0B0A_0908);
        rq[1] = '{0, 2'd0, 32'h06, 32'h0};
        run(0, 1);
        chk("plan_byte6", got_rdata, 32'h0000_0006);
        rq[1] = '{0, 2'd1, 32'h0A, 32'h0};
        run(0, 1);
        chk("plan_half0a", got_rdata, 32'h0000_0B0A);
        rq[0] = '{1, 2'd0, 32'h09, 32'h0000_00AB};
        run(1, 0);
        rq[0] = '{0, 2'd2, 32'h08, 32'h0};
        run(1, 0);
        chk("plan_rmw8", got_rdata, 32'h0B0A_AB08);
        rq[0] = '{0, 2'd2, 32'h02, 32'h0};
        run(1, 0);
        rq[0] = '{1, 2'd1, 32'h03, 32'h1234};
        run(1, 0);
        rq[0] = '{0, 2'd2, 32'h20, 32'h0};
        run(1, 0);
        rq[1] = '{1, 2'd3, 32'h04, 32'h0};
        run(0, 1);

        rq[0] = '{1, 2'd0, 32'h0D, 32'h0000_005A};
        a_req_valid = 1; a_req_we = 1; a_req_size = 0; a_req_addr = 32'h0D; a_req_wdata = 32'h5A;
        b_req_valid = 0;
        #1;
        chk("mid_a_ready", a_req_ready, 1);
        @(posedge clk);
        #1;
        a_req_valid = 0;
        @(negedge clk);
        #1;
        chk("mid_rd", mem_rd, 1);
        @(negedge clk);
        reset = 0;
        #1;
        chk("mid_rst_strobes", {28'b0, mem_rd, mem_wr, a_rsp_valid, b_rsp_valid}, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        last_served = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_quiet", {29'b0, mem_wr, a_rsp_valid, b_rsp_valid}, 0);
        end
        @(negedge clk);
        chk("mid_mem_13", {24'b0, mem[13]}, {24'b0, ref_mem[13]});

        for (int n = 0; n < 200; n++) begin
            int sel;
            rq[0] = rand_req();
            rq[1] = rand_req();
            sel = $urandom_range(1, 3);
            run(sel[0], sel[1]);
        end

        for (int i = 0; i < 32; i++) chk($sformatf("mem_%0d", i), {24'b0, mem[i]}, {24'b0, ref_mem[i]});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
